// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg
// Shared types and helpers for the round-robin stream multiplexer.
//   mux_mode_t : selection mode (round-robin or fixed select)
//   wrap_inc   : modulo-n increment used for the round-robin pointer
package rr_stream_mux_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mux_mode_t;

    // Next index after idx, wrapping to 0 past n-1.
    // Works for any n, not just powers of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if
// Handshake bundle between N_CH producers, the mux, and one consumer.
//   in_valid/in_data/in_ready : per-channel input streams (channel i at [i*W +: W])
//   mode/fixed_sel            : selection control
//   out_valid/out_data/out_ch : registered output stream with source tag
//   out_ready                 : consumer backpressure
// master = environment side (producers + consumer), slave = the mux.
interface rr_stream_mux_if #(
    parameter int N_CH = 4,
    parameter int W    = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_ready;
    logic              mode;
    logic [CH_W-1:0]   fixed_sel;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_ready;

    modport master (
        output in_valid, in_data, mode, fixed_sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, mode, fixed_sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter
// Combinational rotating-priority arbiter.
//   req       : per-channel request
//   ptr       : highest-priority channel this cycle (must be < N_CH)
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : encoded index of the granted channel (0 when no grant)
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    // Scan ptr, ptr+1, ... wrapping by subtraction rather than modulo so
    // non-power-of-two channel counts stay cheap.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] ii;
        logic            found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        ii        = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            ii = CH_W'(idx);
            if (!found && req[ii]) begin
                found     = 1'b1;
                grant[ii] = 1'b1;
                grant_idx = ii;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux
// N_CH-channel, W-bit stream mux with round-robin or fixed selection and a
// single registered output stage tagged with the source channel.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : rr_stream_mux_if.slave (inputs, control, output stream)
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    rr_stream_mux_if.slave bus
);

    typedef struct packed {
        logic [W-1:0]    data;
        logic [CH_W-1:0] ch;
    } beat_t;

    logic [N_CH-1:0][W-1:0] data_arr;
    logic [CH_W-1:0]        ptr;
    logic [N_CH-1:0]        grant_rr, grant_fx, grant;
    logic [CH_W-1:0]        idx_rr, gidx;
    logic                   load_en, fire, out_valid;
    beat_t                  beat_q;
    mux_mode_t              mode_e;

    assign data_arr = bus.in_data;
    assign mode_e   = mux_mode_t'(bus.mode);

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (bus.in_valid),
        .ptr       (ptr),
        .grant     (grant_rr),
        .grant_idx (idx_rr)
    );

    // Fixed select: an out-of-range fixed_sel matches no lane, so no grant.
    for (genvar i = 0; i < N_CH; i++) begin : g_fx
        assign grant_fx[i] = bus.in_valid[i] && (int'(bus.fixed_sel) == i);
    end

    assign grant   = (mode_e == MODE_RR) ? grant_rr : grant_fx;
    assign gidx    = (mode_e == MODE_RR) ? idx_rr : bus.fixed_sel;
    assign load_en = !out_valid || bus.out_ready;

    // Gate on rst: out_valid is already 0 in reset, so load_en alone would
    // still let grants through.
    assign bus.in_ready = rst ? '0 : (grant & {N_CH{load_en}});
    assign fire         = |(bus.in_valid & bus.in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            beat_q    <= '0;
            ptr       <= '0;
        end else begin
            if (load_en) begin
                out_valid <= fire;
                if (fire) begin
                    beat_q.data <= data_arr[gidx];
                    beat_q.ch   <= gidx;
                end
            end
            if (fire && mode_e == MODE_RR)
                ptr <= CH_W'(wrap_inc(int'(gidx), N_CH));
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = beat_q.data;
    assign bus.out_ch    = beat_q.ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux
// Directed bench for rr_stream_mux (N_CH=4, W=4): reset, round-robin order,
// sparse wrap, backpressure, fixed mode, mode switch, reset mid-stream.
module tb_rr_stream_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rr_stream_mux_if #(.N_CH(4), .W(4)) bus ();

    rr_stream_mux #(.N_CH(4), .W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("assertion %s", tag);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".data"},  32'(bus.out_data),  32'(d));
        chk({tag, ".ch"},    32'(bus.out_ch),    32'(c));
    endtask

    initial begin
        bus.in_valid  = 4'b0000;
        bus.in_data   = 16'h4321;
        bus.mode      = 1'b0;
        bus.fixed_sel = 2'd0;
        bus.out_ready = 1'b0;

        // Reset with all channels requesting
        tick();
        bus.in_valid = 4'b1111;
        #1;
        chk_out("rst", 1'b0, 4'h0, 2'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rr.first_rdy", 32'(bus.in_ready), 32'b0001);

        // Round-robin, all valid: 1,2,3,4,1 from ch 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("rr%0d", k), 1'b1, 4'((k % 4) + 1), 2'(k % 4));
            chk($sformatf("rr%0d.rdy", k), 32'(bus.in_ready), 32'(1 << ((k + 1) % 4)));
        end
        bus.in_valid = 4'b0000;
        tick();
        chk("rr.drain", 32'(bus.out_valid), 32'd0);
        chk("rr.ptr", 32'(dut.ptr), 32'd1);

        // Sparse with wrap: ch2 grant moves ptr to 3, then 0011 -> ch0, ch1
        bus.in_valid = 4'b0100;
        tick();
        chk_out("sp.ch2", 1'b1, 4'h3, 2'd2);
        chk("sp.ptr3", 32'(dut.ptr), 32'd3);
        bus.in_valid = 4'b0011;
        #1;
        chk("sp.rdy0", 32'(bus.in_ready), 32'b0001);
        tick();
        chk_out("sp.ch0", 1'b1, 4'h1, 2'd0);
        chk("sp.ptr1", 32'(dut.ptr), 32'd1);
        chk("sp.rdy1", 32'(bus.in_ready), 32'b0010);
        tick();
        chk_out("sp.ch1", 1'b1, 4'h2, 2'd1);

        // Backpressure: ch3 beat 0x5 held for 3 cycles
        bus.in_data  = 16'h5321;
        bus.in_valid = 4'b1000;
        tick();
        chk_out("bp.load", 1'b1, 4'h5, 2'd3);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.rdy", k), 32'(bus.in_ready), 32'h0);
            tick();
            chk_out($sformatf("bp%0d", k), 1'b1, 4'h5, 2'd3);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", 32'(bus.in_ready), 32'b0001);
        tick();
        chk_out("bp.next", 1'b1, 4'h1, 2'd0);
        bus.in_valid = 4'b0000;
        tick();
        chk("bp.drain", 32'(bus.out_valid), 32'd0);

        // Fixed mode on ch2 (data 0xA); ptr stays at 1
        bus.mode      = 1'b1;
        bus.fixed_sel = 2'd2;
        bus.in_data   = 16'h5A21;
        bus.in_valid  = 4'b1111;
        #1;
        chk("fx.rdy", 32'(bus.in_ready), 32'b0100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("fx%0d", k), 1'b1, 4'hA, 2'd2);
            chk($sformatf("fx%0d.rdy", k), 32'(bus.in_ready), 32'b0100);
            chk($sformatf("fx%0d.ptr", k), 32'(dut.ptr), 32'd1);
        end
        bus.fixed_sel = 2'd3;
        bus.in_valid  = 4'b0111;
        #1;
        chk("fx3.rdy", 32'(bus.in_ready), 32'h0);
        tick();
        chk("fx3.drain", 32'(bus.out_valid), 32'd0);
        chk("fx3.ptr", 32'(dut.ptr), 32'd1);

        // Mode switch with a held ch1 beat
        bus.mode      = 1'b0;
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b0;
        #1;
        chk("ms.rdy1", 32'(bus.in_ready), 32'b0010);
        tick();
        chk_out("ms.held", 1'b1, 4'h2, 2'd1);
        bus.mode      = 1'b1;
        bus.fixed_sel = 2'd0;
        bus.in_valid  = 4'b0011;
        tick();
        chk_out("ms.still", 1'b1, 4'h2, 2'd1);
        chk("ms.blocked", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 1'b1;
        #1;
        chk("ms.rdy0", 32'(bus.in_ready), 32'b0001);
        tick();
        chk_out("ms.ch0", 1'b1, 4'h1, 2'd0);
        chk("ms.ptr", 32'(dut.ptr), 32'd2);
        bus.in_valid = 4'b0000;
        tick();

        // Reset mid-stream: held ch2 beat is dropped at once
        bus.mode      = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        tick();
        chk_out("mr.held", 1'b1, 4'hA, 2'd2);
        rst = 1'b1;
        #1;
        chk("mr.valid", 32'(bus.out_valid), 32'd0);
        chk("mr.ch", 32'(bus.out_ch), 32'd0);
        chk("mr.rdy", 32'(bus.in_ready), 32'h0);
        chk("mr.ptr", 32'(dut.ptr), 32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("mr.first_rdy", 32'(bus.in_ready), 32'b0001);
        tick();
        chk_out("mr.first", 1'b1, 4'h1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
